// File: rtl/ysyx_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_mem_arb
//  Brief    : Single-port memory arbiter/sequencer between the IFU and the LSU.
//             One bus transaction in flight; byte-lane alignment for stores,
//             lane extraction with sign/zero extension for loads, error
//             responses for misaligned/illegal requests and bus timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_mem_arb #(
    parameter int RR_EN          = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch port
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic        ifu_resp_err,
    output logic [31:0] ifu_rdata,
    // load/store port
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_resp_valid,
    output logic        lsu_resp_err,
    output logic [31:0] lsu_rdata,
    // memory bus
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    // WAIT counter only has to reach TIMEOUT_CYCLES-1
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    localparam logic c_own_ifu = 1'b0;
    localparam logic c_own_lsu = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_owner;
    logic [31:0]        r_addr;
    logic               r_wen;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_req_valid;
    logic [3:0]         r_mem_wmask;
    logic [31:0]        r_mem_wdata;
    logic               r_ifu_resp_valid;
    logic               r_ifu_resp_err;
    logic [31:0]        r_ifu_rdata;
    logic               r_lsu_resp_valid;
    logic               r_lsu_resp_err;
    logic [31:0]        r_lsu_rdata;

    logic               w_grant_ifu;
    logic               w_grant_lsu;
    logic               w_hs;
    logic               w_hs_err;
    logic               w_ifu_err;
    logic               w_lsu_err;
    logic [3:0]         w_st_mask;
    logic [31:0]        w_st_data;
    logic [7:0]         w_ld_byte;
    logic [15:0]        w_ld_half;
    logic [31:0]        w_ld_data;
    logic [31:0]        w_resp_data;
    logic               w_timeout;
    logic               w_fin;
    logic               w_fin_err;
    logic               w_fin_owner;
    logic [31:0]        w_fin_data;

    // Grant selection: only in IDLE, only to a requester that is valid
    always_comb begin
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        if ((r_state == S_IDLE) && !rst) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (RR_EN != 0) begin
                    w_grant_lsu = (r_last_grant == c_own_ifu);
                    w_grant_ifu = (r_last_grant == c_own_lsu);
                end else begin
                    w_grant_lsu = 1'b1;
                end
            end else begin
                w_grant_ifu = ifu_req_valid;
                w_grant_lsu = lsu_req_valid;
            end
        end
    end

    assign ifu_req_ready = w_grant_ifu;
    assign lsu_req_ready = w_grant_lsu;
    assign w_hs          = w_grant_ifu | w_grant_lsu;

    // Request legality: alignment must match the access size
    assign w_ifu_err = |ifu_addr[1:0];
    assign w_lsu_err = (lsu_size == 2'b11)
                     | ((lsu_size == 2'b01) & lsu_addr[0])
                     | ((lsu_size == 2'b10) & (|lsu_addr[1:0]));
    assign w_hs_err  = w_grant_lsu ? w_lsu_err : w_ifu_err;

    // Store lane placement: mask shifted by byte offset, data replicated
    always_comb begin
        w_st_mask = 4'b1111;
        w_st_data = lsu_wdata;
        case (lsu_size)
            2'b00: begin
                w_st_mask = 4'b0001 << lsu_addr[1:0];
                w_st_data = {4{lsu_wdata[7:0]}};
            end
            2'b01: begin
                w_st_mask = 4'b0011 << lsu_addr[1:0];
                w_st_data = {2{lsu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and extension, using the latched request fields
    always_comb begin
        case (r_addr[1:0])
            2'd1:    w_ld_byte = mem_rdata[15:8];
            2'd2:    w_ld_byte = mem_rdata[23:16];
            2'd3:    w_ld_byte = mem_rdata[31:24];
            default: w_ld_byte = mem_rdata[7:0];
        endcase
        w_ld_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_ld_data = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = mem_rdata;
        endcase
        if (r_owner == c_own_ifu) begin
            w_resp_data = mem_rdata;
        end else if (r_wen) begin
            w_resp_data = 32'h0;
        end else begin
            w_resp_data = w_ld_data;
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Response completion: immediate error in IDLE, data or timeout in WAIT
    always_comb begin
        w_fin       = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_data  = 32'h0;
        w_fin_owner = r_owner;
        case (r_state)
            S_IDLE: begin
                w_fin_owner = w_grant_lsu;
                if (w_hs && w_hs_err) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_fin      = 1'b1;
                    w_fin_data = w_resp_data;
                end else if (w_timeout) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer: request latching, bus handshake, wait/timeout, response pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_last_grant     <= c_own_ifu;
            r_owner          <= c_own_ifu;
            r_addr           <= 32'h0;
            r_wen            <= 1'b0;
            r_size           <= 2'b00;
            r_unsigned       <= 1'b0;
            r_cnt            <= '0;
            r_mem_req_valid  <= 1'b0;
            r_mem_wmask      <= 4'h0;
            r_mem_wdata      <= 32'h0;
            r_ifu_resp_valid <= 1'b0;
            r_ifu_resp_err   <= 1'b0;
            r_ifu_rdata      <= 32'h0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_resp_err   <= 1'b0;
            r_lsu_rdata      <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_owner      <= w_grant_lsu;
                        r_last_grant <= w_grant_lsu;
                        r_addr       <= w_grant_lsu ? lsu_addr : ifu_addr;
                        r_wen        <= w_grant_lsu & lsu_wen;
                        r_size       <= w_grant_lsu ? lsu_size : 2'b10;
                        r_unsigned   <= w_grant_lsu & lsu_unsigned;
                        if (w_hs_err) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state         <= S_REQ;
                            r_mem_req_valid <= 1'b1;
                            r_mem_wmask     <= (w_grant_lsu & lsu_wen) ? w_st_mask : 4'h0;
                            r_mem_wdata     <= (w_grant_lsu & lsu_wen) ? w_st_data : 32'h0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_fin) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            r_ifu_resp_valid <= w_fin & (w_fin_owner == c_own_ifu);
            r_lsu_resp_valid <= w_fin & (w_fin_owner == c_own_lsu);
            if (w_fin) begin
                if (w_fin_owner == c_own_lsu) begin
                    r_lsu_resp_err <= w_fin_err;
                    r_lsu_rdata    <= w_fin_data;
                end else begin
                    r_ifu_resp_err <= w_fin_err;
                    r_ifu_rdata    <= w_fin_data;
                end
            end
        end
    end

    assign mem_req_valid  = r_mem_req_valid;
    assign mem_addr       = {r_addr[31:2], 2'b00};
    assign mem_wen        = r_wen;
    assign mem_wmask      = r_mem_wmask;
    assign mem_wdata      = r_mem_wdata;
    assign ifu_resp_valid = r_ifu_resp_valid;
    assign ifu_resp_err   = r_ifu_resp_err;
    assign ifu_rdata      = r_ifu_rdata;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign lsu_resp_err   = r_lsu_resp_err;
    assign lsu_rdata      = r_lsu_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_mem_arb
//  Brief    : Self-checking bench for ysyx_mem_arb with a response scoreboard,
//             a behavioural memory responder and a fixed-priority instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_mem_arb;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_unsigned;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    // fixed-priority instance signals
    logic        f_ifu_valid, f_ifu_ready, f_ifu_resp_valid, f_ifu_resp_err;
    logic [31:0] f_ifu_rdata;
    logic        f_lsu_valid, f_lsu_ready, f_lsu_resp_valid, f_lsu_resp_err;
    logic [31:0] f_lsu_rdata;
    logic        f_mem_req_valid, f_mem_req_ready, f_mem_wen, f_mem_resp_valid;
    logic [31:0] f_mem_addr, f_mem_wdata;
    logic [3:0]  f_mem_wmask;
    logic [31:0] f_ifu_addr = 32'h8000_0000;
    logic [31:0] f_lsu_addr = 32'h8000_0010;
    logic [31:0] f_zero32   = 32'h0;
    logic [31:0] f_mem_rdata = 32'h1111_2222;
    logic [1:0]  f_size     = 2'b10;
    logic        f_zero     = 1'b0;
    logic        f_pend;

    ysyx_mem_arb #(.RR_EN(1), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned), .lsu_wdata(lsu_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    ysyx_mem_arb #(.RR_EN(0), .TIMEOUT_CYCLES(TMO)) dut_fp (
        .clk(clk), .rst(rst),
        .ifu_req_valid(f_ifu_valid), .ifu_req_ready(f_ifu_ready), .ifu_addr(f_ifu_addr),
        .ifu_resp_valid(f_ifu_resp_valid), .ifu_resp_err(f_ifu_resp_err), .ifu_rdata(f_ifu_rdata),
        .lsu_req_valid(f_lsu_valid), .lsu_req_ready(f_lsu_ready), .lsu_addr(f_lsu_addr),
        .lsu_wen(f_zero), .lsu_size(f_size), .lsu_unsigned(f_zero), .lsu_wdata(f_zero32),
        .lsu_resp_valid(f_lsu_resp_valid), .lsu_resp_err(f_lsu_resp_err), .lsu_rdata(f_lsu_rdata),
        .mem_req_valid(f_mem_req_valid), .mem_req_ready(f_mem_req_ready), .mem_addr(f_mem_addr),
        .mem_wen(f_mem_wen), .mem_wmask(f_mem_wmask), .mem_wdata(f_mem_wdata),
        .mem_resp_valid(f_mem_resp_valid), .mem_rdata(f_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lsu;
        logic        err;
        logic [31:0] data;
        int          hs_cyc;
        int          lat;      // 0 = timeout window check
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } mexp_t;

    exp_t        sb[$];
    mexp_t       mq[$];
    logic        grant_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        mem_hang = 1'b0;
    logic [31:0] mem_word = 32'h0;
    int          force_req = 0;
    int          force_ack = 0;
    logic        resp_pend = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err   = 1'b0;
    logic [31:0] last_maddr = 32'h0;
    logic [3:0]  last_mask  = 4'h0;
    logic [31:0] last_mwdata = 32'h0;
    logic        last_mwen  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic bad_req(input logic lsu, input logic [31:0] a, input logic [1:0] s);
        if (!lsu)        return a[1:0] != 2'b00;
        if (s == 2'b11)  return 1'b1;
        if (s == 2'b01)  return a[0];
        if (s == 2'b10)  return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] s, input logic u);
        logic [31:0] v;
        int sh;
        if (s == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v  = (w >> sh) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (s == 2'b01) begin
            sh = a[1] ? 16 : 0;
            v  = (w >> sh) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Scoreboard push at request acceptance: response and bus expectations
    task automatic push_req(input logic lsu, input logic [31:0] a, input logic w,
                            input logic [1:0] s, input logic u, input logic [31:0] d);
        exp_t  e;
        mexp_t m;
        grant_log.push_back(lsu);
        e.lsu = lsu; e.hs_cyc = cyc;
        if (bad_req(lsu, a, s)) begin
            e.err = 1'b1; e.data = 32'h0; e.lat = 1;
        end else begin
            if (mem_hang) begin
                e.err = 1'b1; e.data = 32'h0; e.lat = 0;
            end else begin
                e.err = 1'b0; e.lat = 3;
                e.data = (lsu && w) ? 32'h0 : (lsu ? load_val(mem_word, a, s, u) : mem_word);
            end
            m.addr = {a[31:2], 2'b00};
            m.wen  = lsu & w;
            m.mask = !(lsu && w) ? 4'h0 : (s == 2'b00) ? (4'b0001 << a[1:0]) :
                     (s == 2'b01) ? (4'b0011 << a[1:0]) : 4'hF;
            m.wdata = !(lsu && w) ? 32'h0 : (s == 2'b00) ? {4{d[7:0]}} :
                      (s == 2'b01) ? {2{d[15:0]}} : d;
            mq.push_back(m);
        end
        sb.push_back(e);
    endtask

    task automatic run_monitor();
        exp_t        e;
        mexp_t       m;
        logic [31:0] rd;
        logic        er;
        int          lat;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                sb.delete();
                mq.delete();
            end else begin
                if (ifu_req_valid && lsu_req_valid)
                    chk("one_grant", 32'(ifu_req_ready & lsu_req_ready), 32'h0);
                if (lsu_req_valid && lsu_req_ready)
                    push_req(1'b1, lsu_addr, lsu_wen, lsu_size, lsu_unsigned, lsu_wdata);
                else if (ifu_req_valid && ifu_req_ready)
                    push_req(1'b0, ifu_addr, 1'b0, 2'b10, 1'b0, 32'h0);
                if (mem_req_valid && mem_req_ready) begin
                    if (mq.size() == 0) begin
                        chk("mem_unexpected", 32'(mem_req_valid), 32'h0);
                    end else begin
                        m = mq.pop_front();
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_wen", 32'(mem_wen), 32'(m.wen));
                        chk("mem_wmask", 32'(mem_wmask), 32'(m.mask));
                        chk("mem_wdata", mem_wdata, m.wdata);
                        last_maddr = mem_addr; last_mask = mem_wmask;
                        last_mwdata = mem_wdata; last_mwen = mem_wen;
                    end
                end
                if (ifu_resp_valid || lsu_resp_valid) begin
                    if (sb.size() == 0) begin
                        chk("resp_unexpected", {30'h0, ifu_resp_valid, lsu_resp_valid}, 32'h0);
                    end else begin
                        e   = sb.pop_front();
                        rd  = e.lsu ? lsu_rdata : ifu_rdata;
                        er  = e.lsu ? lsu_resp_err : ifu_resp_err;
                        lat = cyc - e.hs_cyc;
                        chk("resp_owner", {30'h0, ifu_resp_valid, lsu_resp_valid},
                            e.lsu ? 32'h1 : 32'h2);
                        chk("resp_err", 32'(er), 32'(e.err));
                        chk("resp_rdata", rd, e.data);
                        if (e.lat != 0)
                            chk("resp_latency", 32'(lat), 32'(e.lat));
                        else
                            chk("timeout_window", 32'((lat >= TMO + 1) && (lat <= TMO + 3)), 32'h1);
                        last_rdata = rd; last_err = er;
                    end
                end
            end
        end
    endtask

    // Memory: accept at once, answer one cycle later unless hung
    task automatic run_memory();
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (resp_pend || (force_req != force_ack)) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = mem_word;
                resp_pend      = 1'b0;
                force_ack      = force_req;
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                mem_req_ready = 1'b1;
                if (!mem_hang) resp_pend = 1'b1;
            end
            f_mem_resp_valid = f_pend;
            f_pend           = f_mem_req_valid;
        end
    endtask

    task automatic run_cycles();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic ifu_go(input logic [31:0] a);
        int k = 0;
        @(negedge clk);
        ifu_addr = a; ifu_req_valid = 1'b1;
        #1;
        while (!ifu_req_ready && k < 50) begin @(negedge clk); #1; k++; end
        chk("ifu_accept", 32'(ifu_req_ready), 32'h1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_go(input logic [31:0] a, input logic w, input logic [1:0] s,
                          input logic u, input logic [31:0] d);
        int k = 0;
        @(negedge clk);
        lsu_addr = a; lsu_wen = w; lsu_size = s; lsu_unsigned = u; lsu_wdata = d;
        lsu_req_valid = 1'b1;
        #1;
        while (!lsu_req_ready && k < 50) begin @(negedge clk); #1; k++; end
        chk("lsu_accept", 32'(lsu_req_ready), 32'h1);
        @(posedge clk); #1;
        lsu_req_valid = 1'b0;
    endtask

    task automatic drain(input int bound, input string tag);
        int k = 0;
        while (sb.size() != 0 && k < bound) begin @(negedge clk); #3; k++; end
        chk({tag, "_drain"}, 32'(sb.size()), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        int g0, fl, fi, k;
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h0;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_size = 2'b10;
        lsu_unsigned = 1'b0; lsu_wdata = 32'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        f_ifu_valid = 1'b0; f_lsu_valid = 1'b0; f_mem_req_ready = 1'b1;
        f_mem_resp_valid = 1'b0; f_pend = 1'b0;
        fork
            run_monitor();
            run_memory();
            run_cycles();
            begin #2_000_000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end
        join_none

        // reset state, with requests pending to show ready stays low
        repeat (3) @(negedge clk);
        #1;
        chk("rst_flags", {20'h0, ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen,
                          ifu_resp_valid, ifu_resp_err, lsu_resp_valid, lsu_resp_err, 4'h0}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        chk("rst_rdata", ifu_rdata | lsu_rdata, 32'h0);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // instruction fetch
        mem_word = 32'h0010_0093;
        ifu_go(32'h8000_0004); drain(20, "fetch");
        chk("fetch_rdata", last_rdata, 32'h0010_0093);
        chk("fetch_addr", last_maddr, 32'h8000_0004);
        chk("fetch_mask", 32'(last_mask), 32'h0);

        // byte loads, signed then unsigned
        mem_word = 32'h80FF_1234;
        lsu_go(32'h8000_0103, 1'b0, 2'b00, 1'b0, 32'h0); drain(20, "lb");
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        lsu_go(32'h8000_0103, 1'b0, 2'b00, 1'b1, 32'h0); drain(20, "lbu");
        chk("lbu_rdata", last_rdata, 32'h0000_0080);
        lsu_go(32'h8000_0102, 1'b0, 2'b01, 1'b0, 32'h0); drain(20, "lh");
        lsu_go(32'h8000_0102, 1'b0, 2'b01, 1'b1, 32'h0); drain(20, "lhu");
        lsu_go(32'h8000_0100, 1'b0, 2'b01, 1'b0, 32'h0); drain(20, "lh0");
        lsu_go(32'h8000_0100, 1'b0, 2'b10, 1'b0, 32'h0); drain(20, "lw");

        // stores
        lsu_go(32'h8000_0102, 1'b1, 2'b01, 1'b0, 32'h0000_ABCD); drain(20, "sh");
        chk("sh_mask", 32'(last_mask), 32'hC);
        chk("sh_wdata", last_mwdata, 32'hABCD_ABCD);
        chk("sh_wen", 32'(last_mwen), 32'h1);
        chk("sh_rdata", last_rdata, 32'h0);
        chk("sh_err", 32'(last_err), 32'h0);
        lsu_go(32'h8000_0001, 1'b1, 2'b00, 1'b0, 32'h0000_005A); drain(20, "sb");
        lsu_go(32'h8000_0008, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF); drain(20, "sw");

        // error requests; the IFU one last so last_grant ends on IFU
        lsu_go(32'h8000_0002, 1'b0, 2'b10, 1'b0, 32'h0); drain(20, "lw_mis");
        chk("lw_mis_err", 32'(last_err), 32'h1);
        lsu_go(32'h8000_0001, 1'b1, 2'b01, 1'b0, 32'h0); drain(20, "sh_mis");
        lsu_go(32'h8000_0000, 1'b0, 2'b11, 1'b0, 32'h0); drain(20, "size11");
        ifu_go(32'h8000_0001); drain(20, "ifu_mis");
        chk("ifu_mis_err", 32'(last_err), 32'h1);

        // round robin with both requesters held valid
        mem_word = 32'h1357_9BDF;
        g0 = grant_log.size();
        @(negedge clk);
        ifu_addr = 32'h8000_0010; ifu_req_valid = 1'b1;
        lsu_addr = 32'h8000_0020; lsu_wen = 1'b0; lsu_size = 2'b10; lsu_unsigned = 1'b0;
        lsu_req_valid = 1'b1;
        k = 0;
        while (grant_log.size() < g0 + 4 && k < 60) begin @(negedge clk); #3; k++; end
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        drain(20, "rr");
        chk("rr_count", 32'(grant_log.size() - g0), 32'h4);
        if (grant_log.size() >= g0 + 4) begin
            chk("rr_g0", 32'(grant_log[g0]),     32'h1);
            chk("rr_g1", 32'(grant_log[g0 + 1]), 32'h0);
            chk("rr_g2", 32'(grant_log[g0 + 2]), 32'h1);
            chk("rr_g3", 32'(grant_log[g0 + 3]), 32'h0);
        end

        // bus timeout
        mem_hang = 1'b1;
        lsu_go(32'h8000_0040, 1'b0, 2'b10, 1'b0, 32'h0); drain(TMO + 20, "timeout");
        chk("timeout_err", 32'(last_err), 32'h1);

        // reset while waiting on the bus
        ifu_go(32'h8000_0080);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_wait_flags", {28'h0, mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready},
            32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        force_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            chk("rst_no_resp", 32'(ifu_resp_valid | lsu_resp_valid), 32'h0);
        end
        mem_hang = 1'b0;
        mem_word = 32'h1234_5678;
        ifu_go(32'h8000_0100); drain(20, "post_rst");
        chk("post_rst_rdata", last_rdata, 32'h1234_5678);

        // fixed LSU priority instance
        fl = 0; fi = 0;
        @(negedge clk);
        f_ifu_valid = 1'b1; f_lsu_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (f_lsu_ready) fl++;
            if (f_ifu_ready) fi++;
            @(negedge clk);
        end
        chk("fp_ifu_grants", 32'(fi), 32'h0);
        chk("fp_lsu_grants", 32'(fl >= 4), 32'h1);
        f_lsu_valid = 1'b0;
        k = 0;
        #1;
        while (!f_ifu_ready && k < 10) begin @(negedge clk); #1; k++; end
        chk("fp_ifu_after", 32'(f_ifu_ready), 32'h1);
        @(posedge clk); #1;
        f_ifu_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_mem_arb.md
Name: ysyx_mem_arb

Overview:
- Single-port memory arbiter and sequencer between the IFU (instruction fetch, read-only) and the LSU (EXU load/store path).
- Owns the only memory bus; one transaction in flight at a time.
- Performs byte-lane alignment: store mask and data replication; load extraction with sign or zero extension.
- Flags misaligned accesses, illegal sizes and bus timeouts as error responses.

Parameters:
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed LSU priority.
- TIMEOUT_CYCLES, 255, WAIT-state cycles without mem_resp_valid before an error response.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch accepted
- ifu_addr  in  32  fetch address
- ifu_resp_valid  out  1  one-cycle response pulse
- ifu_resp_err  out  1  error qualifier for the response
- ifu_rdata  out  32  instruction word
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  accepted
- lsu_addr  in  32  byte address
- lsu_wen  in  1  1 = store
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- lsu_unsigned  in  1  zero-extend loads
- lsu_wdata  in  32  store data, right-aligned
- lsu_resp_valid  out  1  one-cycle response pulse
- lsu_resp_err  out  1  error qualifier for the response
- lsu_rdata  out  32  extended load data; 0 on stores
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accept
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wen  out  1  write
- mem_wmask  out  4  byte enables; 0 on reads
- mem_wdata  out  32  lane-replicated store data
- mem_resp_valid  in  1  bus response, reads and writes
- mem_rdata  in  32  read word

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - State IDLE, last_grant = IFU.
  - All valid/ready/err outputs 0; all data, address and mask outputs 0.
  - Reset mid-transaction drops mem_req_valid immediately and discards the pending response. No response is ever issued for it.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - x_req_ready is asserted combinationally only for the winner among asserted valids.
  - Single requester: it wins.
  - Both requesting: RR_EN=1 grants the requester that is not last_grant; RR_EN=0 grants the LSU.
  - Handshake (valid & ready) in cycle T:
    - latch addr, wen, size, unsigned, wdata and owner;
    - update last_grant, including for error requests;
    - go to REQ, or to RESP with err if the checks fail.
  - ready is 0 in all other states.
- Error checks:
  - IFU: addr[1:0] != 0.
  - LSU: size 11; half with addr[0] = 1; word with addr[1:0] != 0.
  - Error path: RESP at T+1 with err = 1 and rdata = 0. No bus activity.
- REQ:
  - mem_req_valid = 1 with all mem_* fields stable from the latches.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - mem_req_valid = 0; the counter resets on entry.
  - mem_resp_valid moves to RESP. The data path:
    - captures mem_rdata;
    - extracts the lane and extends it for LSU loads;
    - passes the full word for the IFU;
    - returns 0 for stores.
  - Memory never asserts mem_resp_valid in the same cycle as mem_req_ready; earliest is the next cycle.
  - Counter reaching TIMEOUT_CYCLES moves to RESP with err = 1 and rdata = 0.
  - A late mem_resp_valid while outside WAIT is ignored.
- RESP:
  - The owner's resp_valid = 1 for exactly one cycle, with rdata and err registered.
  - Next state is IDLE.
  - Requesters have no backpressure on responses.
- Best-case latency: handshake T, mem_req_valid at T+1, mem_req_ready at T+1, mem_resp_valid at T+2, resp_valid at T+3, ready again at T+4.
- Store lanes, with off = addr[1:0]:
  - byte: wmask = 0001 << off, wdata = {4{wdata[7:0]}}
  - half: wmask = 0011 << off, wdata = {2{wdata[15:0]}}
  - word: wmask = 1111
- Load extraction:
  - byte: rdata[8*off+7 : 8*off]
  - half: rdata[16*addr[1]+15 : 16*addr[1]]
  - Sign-extend when unsigned = 0, else zero-extend.
- Requesters hold valid and fields until ready. The block does not cache requests it has not accepted.

Test Plan:
- IFU fetch at 0x80000004, mem_req_ready at once, mem_rdata 0x00100093 one cycle later -> mem_addr 0x80000004, wmask 0; ifu_resp_valid pulse with ifu_rdata 0x00100093 and err 0, exactly 3 cycles after the handshake.
- LSU signed lb at 0x80000103 with mem_rdata 0x80FF1234 -> lsu_rdata 0xFFFFFF80. The same access with lsu_unsigned=1 -> 0x00000080.
- LSU sh at 0x80000102 with wdata 0x0000ABCD -> mem_wmask 1100, mem_wdata 0xABCDABCD, mem_wen 1. Response has rdata 0, err 0.
- Both valid continuously for 4 transactions with RR_EN=1 -> grant order LSU, IFU, LSU, IFU. With RR_EN=0 -> LSU only while lsu_req_valid stays high.
- Error cases:
  - lw at 0x80000002 -> lsu_resp_err pulse at T+1, no mem_req_valid.
  - WAIT with no mem_resp_valid -> err after TIMEOUT_CYCLES (255).
- rst asserted in WAIT -> mem_req_valid and all resp outputs 0 immediately. A following mem_resp_valid produces no response. The next IFU request is served normally.
